// File: rtl/debouncer_pkg.sv
// Shared types for the multi-channel debouncer: operating mode and per-channel state.
package debouncer_pkg;

  typedef enum logic {
    MODE_LOCKOUT   = 1'b0,
    MODE_INTEGRATE = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOCK = 2'd1,
    QUAL = 2'd2
  } ch_state_e;

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: lockout (pass first edge, then ignore) or integrate (pass after stable period).
module debounce_channel
  import debouncer_pkg::*;
#(
  parameter int    HOLD_CYCLES = 4194304,
  parameter mode_e MODE        = MODE_LOCKOUT
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic s_i,
  output logic debounce_o,
  output logic rise_o,
  output logic fall_o,
  output logic busy_o
);

  localparam int CW = $clog2(HOLD_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_CYCLES - 1);

  ch_state_e      state;
  logic [CW-1:0]  cnt;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= IDLE;
      cnt        <= '0;
      debounce_o <= 1'b0;
      rise_o     <= 1'b0;
      fall_o     <= 1'b0;
    end else begin
      rise_o <= 1'b0;
      fall_o <= 1'b0;
      case (state)
        IDLE: begin
          if (s_i != debounce_o) begin
            cnt <= CW'(1);
            if (MODE == MODE_LOCKOUT) begin
              debounce_o <= s_i;
              rise_o     <= s_i;
              fall_o     <= ~s_i;
              state      <= LOCK;
            end else begin
              state <= QUAL;
            end
          end
        end
        // Input is ignored for the whole lockout; re-sampled on the first IDLE edge.
        LOCK: begin
          if (cnt == CNT_LAST) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        QUAL: begin
          if (s_i == debounce_o) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            debounce_o <= s_i;
            rise_o     <= s_i;
            fall_o     <= ~s_i;
            state      <= IDLE;
            cnt        <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign busy_o = (state != IDLE);

endmodule

// File: rtl/multi_debouncer.sv
// NCH independent debounce channels. Define DEBOUNCER_SYNC_EN to add a 2-flop
// synchroniser on every bounce_i bit (2 cycles extra latency).
module multi_debouncer
  import debouncer_pkg::*;
#(
  parameter int    NCH         = 4,
  parameter int    HOLD_CYCLES = 4194304,
  parameter mode_e MODE        = MODE_LOCKOUT
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  input  logic [NCH-1:0] bounce_i,
  output logic [NCH-1:0] debounce_o,
  output logic [NCH-1:0] rise_o,
  output logic [NCH-1:0] fall_o,
  output logic [NCH-1:0] busy_o
);

  logic [NCH-1:0] s;

`ifdef DEBOUNCER_SYNC_EN
  logic [NCH-1:0] sync_q1, sync_q2;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= bounce_i;
      sync_q2 <= sync_q1;
    end
  end

  assign s = sync_q2;
`else
  assign s = bounce_i;
`endif

  for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
    debounce_channel #(
      .HOLD_CYCLES (HOLD_CYCLES),
      .MODE        (MODE)
    ) u_ch (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .s_i        (s[ch]),
      .debounce_o (debounce_o[ch]),
      .rise_o     (rise_o[ch]),
      .fall_o     (fall_o[ch]),
      .busy_o     (busy_o[ch])
    );
  end

endmodule

// File: tb/tb_multi_debouncer.sv
// Scoreboarded bench: lockout and integrate instances share stimulus and are checked
// against a run-length/lockout-timer reference model every cycle.
module tb_multi_debouncer;
  import debouncer_pkg::*;

  localparam int NCH  = 4;
  localparam int HOLD = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [NCH-1:0] bounce = '0;

  logic [NCH-1:0] deb_l, rise_l, fall_l, busy_l;
  logic [NCH-1:0] deb_i, rise_i, fall_i, busy_i;

  multi_debouncer #(.NCH(NCH), .HOLD_CYCLES(HOLD), .MODE(MODE_LOCKOUT)) u_dut_lock (
    .clk_i(clk), .rst_n_i(rst_n), .bounce_i(bounce),
    .debounce_o(deb_l), .rise_o(rise_l), .fall_o(fall_l), .busy_o(busy_l)
  );

  multi_debouncer #(.NCH(NCH), .HOLD_CYCLES(HOLD), .MODE(MODE_INTEGRATE)) u_dut_int (
    .clk_i(clk), .rst_n_i(rst_n), .bounce_i(bounce),
    .debounce_o(deb_i), .rise_o(rise_i), .fall_o(fall_i), .busy_o(busy_i)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NCH-1:0] dl, rl, fl, bl;
    logic [NCH-1:0] di, ri, fi, bi;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: lockout = "cycles of lockout remaining", integrate = "length of
  // the current run of samples disagreeing with the output".
  int             lock_left [NCH];
  int             run       [NCH];
  logic [NCH-1:0] m_dl, m_rl, m_fl, m_di, m_ri, m_fi;
  logic [NCH-1:0] h1, h2;

  function automatic void model_reset();
    for (int c = 0; c < NCH; c++) begin
      lock_left[c] = 0;
      run[c]       = 0;
    end
    m_dl = '0; m_rl = '0; m_fl = '0;
    m_di = '0; m_ri = '0; m_fi = '0;
    h1 = '0; h2 = '0;
  endfunction

  function automatic void model_step(input logic [NCH-1:0] b);
    logic [NCH-1:0] s;
`ifdef DEBOUNCER_SYNC_EN
    s  = h2;
    h2 = h1;
    h1 = b;
`else
    s = b;
`endif
    m_rl = '0; m_fl = '0; m_ri = '0; m_fi = '0;
    for (int c = 0; c < NCH; c++) begin
      if (lock_left[c] > 0) begin
        lock_left[c]--;
      end else if (s[c] != m_dl[c]) begin
        m_dl[c]      = s[c];
        m_rl[c]      = s[c];
        m_fl[c]      = ~s[c];
        lock_left[c] = HOLD - 1;
      end
      if (s[c] != m_di[c]) begin
        run[c]++;
        if (run[c] == HOLD) begin
          m_di[c] = s[c];
          m_ri[c] = s[c];
          m_fi[c] = ~s[c];
          run[c]  = 0;
        end
      end else begin
        run[c] = 0;
      end
    end
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.dl = m_dl; e.rl = m_rl; e.fl = m_fl;
    e.di = m_di; e.ri = m_ri; e.fi = m_fi;
    for (int c = 0; c < NCH; c++) begin
      e.bl[c] = (lock_left[c] > 0);
      e.bi[c] = (run[c] > 0);
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [NCH-1:0] act, input logic [NCH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b want %b", name, $time, act, exp);
    end
  endtask

  // One clock: account for the edge just taken, then apply reset level and next input.
  task automatic cycle(input logic [NCH-1:0] nb, input logic rst_val);
    @(posedge clk);
    #1;
    if (rst_n) model_step(bounce);
    else       model_reset();
    rst_n = rst_val;
    if (!rst_val) model_reset();
    q.push_back(model_out());
    bounce = nb;
  endtask

  task automatic hold(input logic [NCH-1:0] nb, input int n);
    for (int i = 0; i < n; i++) cycle(nb, 1'b1);
  endtask

  // Monitor: outputs are valid every cycle, so pop one expectation per negedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("lock_debounce", deb_l,  e.dl);
        check("lock_rise",     rise_l, e.rl);
        check("lock_fall",     fall_l, e.fl);
        check("lock_busy",     busy_l, e.bl);
        check("int_debounce",  deb_i,  e.di);
        check("int_rise",      rise_i, e.ri);
        check("int_fall",      fall_i, e.fi);
        check("int_busy",      busy_i, e.bi);
      end
    end
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: simulation did not complete");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    logic [NCH-1:0] b;
    model_reset();
    for (int i = 0; i < 3; i++) cycle('0, 1'b0);
    hold('0, 4);

    // Ch0 rising with bounce, ch1 short pulse that must not be lost in lockout.
    hold(4'b0011, 2);
    hold(4'b0001, 1);
    hold(4'b0000, 1);
    hold(4'b0001, 1);
    hold(4'b0000, 1);
    hold(4'b0001, 14);

    // Ch2: 5-cycle glitch rejected by integrate, then an 8+ cycle hold accepted.
    hold(4'b0101, 5);
    hold(4'b0001, 6);
    hold(4'b0101, 12);

    // Ch3: reset in the middle of a lockout/qualify period with input held high.
    hold(4'b1101, 3);
    cycle(4'b1101, 1'b0);
    cycle(4'b1101, 1'b0);
    hold(4'b1101, 14);

    // All channels fall together, then all rise together.
    hold(4'b0000, 12);
    hold(4'b1111, 12);

    // Randomised bouncing with occasional resets.
    b = bounce;
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < NCH; c++)
        if ($urandom_range(5) == 0) b[c] = ~b[c];
      cycle(b, ($urandom_range(199) == 0) ? 1'b0 : 1'b1);
      if ($urandom_range(9) == 0) hold(b, $urandom_range(12, 4));
    end
    hold(b, 12);

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_debouncer.md
MULTI_DEBOUNCER -- requirements
Module: multi_debouncer

Interface
REQ-001 SHALL have parameter NCH, default 4: number of independent channels, 1..32.
REQ-002 SHALL have parameter HOLD_CYCLES, default 4194304: debounce period in clk_i cycles (83.89 ms at 50 MHz), minimum 2.
REQ-003 SHALL have parameter MODE, default MODE_LOCKOUT: MODE_LOCKOUT (transfer immediately, then ignore input) or MODE_INTEGRATE (transfer only after stable period).
REQ-004 SHALL have port clk_i, input, 1: clock.
REQ-005 SHALL have port rst_n_i, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port bounce_i, input, NCH: raw contact inputs, one bit per channel.
REQ-007 SHALL have port debounce_o, output, NCH: debounced level per channel.
REQ-008 SHALL have port rise_o, output, NCH: one-cycle pulse on each 0->1 transition of debounce_o.
REQ-009 SHALL have port fall_o, output, NCH: one-cycle pulse on each 1->0 transition of debounce_o.
REQ-010 SHALL have port busy_o, output, NCH: high while a channel is not in IDLE.

Function
REQ-011 SHALL process channels independently; no channel's activity SHALL affect another's timing or outputs.
REQ-012 SHALL use a per-channel sample s: bounce_i[ch] directly, or the synchronised value (REQ-025).
REQ-013 SHALL implement per-channel states IDLE, LOCK (lockout mode only), QUAL (integrate mode only).
REQ-014 SHALL use a per-channel counter of width $clog2(HOLD_CYCLES); no wrap-around occurs because the counter is cleared on every return to IDLE.
REQ-015 Lockout mode: in IDLE with s != debounce_o, on that edge SHALL set debounce_o <= s, pulse rise_o/fall_o, load counter 1, enter LOCK.
REQ-016 Lockout mode: in LOCK SHALL ignore s and increment the counter; at count HOLD_CYCLES-1 SHALL return to IDLE, clear the counter, and sample s again on the next edge.
REQ-017 Lockout mode: a level differing from debounce_o when LOCK ends SHALL be transferred on the first IDLE edge (no edge is lost).
REQ-018 Integrate mode: in IDLE with s != debounce_o SHALL enter QUAL with counter 1; debounce_o SHALL be unchanged.
REQ-019 Integrate mode: in QUAL, s == debounce_o on any edge SHALL return to IDLE and clear the counter (glitch rejected, no pulse).
REQ-020 Integrate mode: in QUAL, s != debounce_o at count HOLD_CYCLES-1 SHALL set debounce_o <= s, pulse rise_o/fall_o, return to IDLE.
REQ-021 rise_o and fall_o SHALL be registered, high for exactly the one cycle after debounce_o changes, and never both high on one channel.
REQ-022 busy_o[ch] SHALL be 1 exactly when the channel is in LOCK or QUAL.

Reset
REQ-023 On rst_n_i low SHALL immediately force debounce_o, rise_o, fall_o, busy_o, all counters and synchroniser flops to 0, and all states to IDLE.
REQ-024 Reset asserted mid-LOCK or mid-QUAL SHALL abort the period; after release, a channel with s=1 SHALL be treated as a fresh 0->1 event.

Configuration
REQ-025 With DEBOUNCER_SYNC_EN defined, each bounce_i bit SHALL pass through a 2-flop synchroniser, adding exactly 2 cycles of latency; without it, s = bounce_i[ch] and bounce_i SHALL be synchronous to clk_i.

Structure
REQ-026 Package debouncer_pkg SHALL hold the mode enum (MODE_LOCKOUT, MODE_INTEGRATE) and the channel state typedef (IDLE, LOCK, QUAL).
REQ-027 Per-channel logic SHALL be a sub-module debounce_channel, instantiated NCH times by generate; the top holds only the optional synchronisers.

Verification (HOLD_CYCLES=8, NCH=4, no DEBOUNCER_SYNC_EN unless stated)
REQ-028 Lockout: bounce_i[0] 0->1 at edge 10, toggling until edge 14 -> debounce_o[0]=1 after edge 10, rise_o[0] high one cycle, busy_o[0] high 7 cycles, no further pulses.
REQ-029 Lockout, lost-edge check: bounce_i[1] 1 at edge 5, 0 at edge 7 -> debounce_o[1] rises at edge 5, falls at the first IDLE edge after LOCK, fall_o[1] one pulse.
REQ-030 Integrate: bounce_i[2] high for 5 cycles then low -> debounce_o[2] stays 0, no pulses; held high 8 cycles -> debounce_o[2]=1 8 edges after first high sample.
REQ-031 Reset mid-LOCK on channel 3 with bounce_i[3]=1 held -> all outputs 0 during reset; rise_o[3] pulses on the first edge after release.
REQ-032 DEBOUNCER_SYNC_EN: REQ-028 stimulus -> identical response delayed exactly 2 cycles; simultaneous events on all 4 channels -> 4 independent rise_o pulses on the same cycle.
